// File: rtl/ddr_package.sv
// Shared types and constants for the DDR4 command sequencer.
// Contents: field widths, rw encodings, the upstream transaction struct,
// the decoded-address struct, the command code enum, the FSM state enum and
// an address decode helper.
// Config macro: OPEN_PAGE_EN adds the StOpen state to the FSM enum.
package ddr_package;

    localparam int unsigned AddrW = 29;
    localparam int unsigned DataW = 64;
    localparam int unsigned BgW   = 2;
    localparam int unsigned BaW   = 2;
    localparam int unsigned RowW  = 15;
    localparam int unsigned ColW  = 10;

    localparam logic [1:0] RwRead  = 2'b01;
    localparam logic [1:0] RwWrite = 2'b10;

    typedef enum logic [2:0] {
        CmdNop = 3'd0,
        CmdAct = 3'd1,
        CmdRd  = 3'd2,
        CmdWr  = 3'd3,
        CmdPre = 3'd4
    } cmd_code_t;

    typedef struct packed {
        logic [AddrW-1:0] physical_addr;
        logic [DataW-1:0] data_wr;
        logic [1:0]       rw;
    } input_data_type;

    typedef struct packed {
        logic [BgW-1:0]  bg;
        logic [BaW-1:0]  ba;
        logic [RowW-1:0] row;
        logic [ColW-1:0] col;
    } ddr_addr_t;

    typedef enum logic [2:0] {
        StIdle,
        StAct,
        StWaitRcd,
        StCas,
        StPre,
        StWaitRp
`ifdef OPEN_PAGE_EN
        , StOpen
`endif
    } seq_state_t;

    // addr = {row, bg, ba, col}
    function automatic ddr_addr_t decode_addr(input logic [AddrW-1:0] addr);
        ddr_addr_t d;
        d.col = addr[ColW-1:0];
        d.ba  = addr[ColW+BaW-1:ColW];
        d.bg  = addr[ColW+BaW+BgW-1:ColW+BaW];
        d.row = addr[AddrW-1:ColW+BaW+BgW];
        return d;
    endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Bus bundle between upstream stimulus, the sequencer and the DRAM command port.
// Signals: act_cmd/data (upstream strobe + transaction), dev_busy (backpressure),
// cmd_valid/cmd_ready handshake, cmd_code/bg/ba/row/col/data command fields,
// overflow (sticky drop flag).
// Modports: master = sequencer side, slave = environment side.
interface cmd_sequencer_if;
    import ddr_package::*;

    logic            act_cmd;
    input_data_type  data;
    logic            dev_busy;
    logic            cmd_valid;
    logic            cmd_ready;
    cmd_code_t       cmd_code;
    logic [BgW-1:0]  cmd_bg;
    logic [BaW-1:0]  cmd_ba;
    logic [RowW-1:0] cmd_row;
    logic [ColW-1:0] cmd_col;
    logic [DataW-1:0] cmd_data;
    logic            overflow;

    modport master (
        input  act_cmd, data, cmd_ready,
        output dev_busy, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data,
               overflow
    );

    modport slave (
        output act_cmd, data, cmd_ready,
        input  dev_busy, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data,
               overflow
    );

endinterface

// File: rtl/cmd_fifo.sv
// Transaction queue for the command sequencer.
// Ports: clk_i, rst_ni (async active-low), push_i/data_i (write, ignored when
// full), pop_i (read, ignored when empty), data_o (head entry), full_o, empty_o,
// count_o (occupancy). DEPTH must be a power of two so pointers wrap naturally.
module cmd_fifo
    import ddr_package::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  input_data_type           data_i,
    input  logic                     pop_i,
    output input_data_type           data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    input_data_type  mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (do_push && !do_pop) count_d = count_q + (PtrW+1)'(1);
        if (!do_push && do_pop) count_d = count_q - (PtrW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cmd_sequencer.sv
// DDR4 command sequencer: queues upstream read/write transactions and issues
// ACT -> RD/WR -> PRE sequences with tRCD/tRP spacing on a valid/ready bus.
// Ports: clock_t, reset_n (async active-low), bus (cmd_sequencer_if.master).
// Parameters: DEPTH (queue entries, power of two >= 4), T_RCD, T_RP (>= 1).
// Config macro: OPEN_PAGE_EN keeps the row open after CAS and serves page hits
// straight from CAS; otherwise every transaction is closed-page.
module cmd_sequencer
    import ddr_package::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned T_RCD = 4,
    parameter int unsigned T_RP  = 4
) (
    input  logic              clock_t,
    input  logic              reset_n,
    cmd_sequencer_if.master   bus
);

    localparam int unsigned OccW   = $clog2(DEPTH) + 1;
    localparam int unsigned CntMax = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    seq_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    input_data_type hold_q, hold_d;
    logic           dev_busy_q, dev_busy_d;
    logic           overflow_q, overflow_d;

    logic           push, pop;
    input_data_type head;
    logic           full, empty;
    logic [OccW-1:0] count, occ_next;
    ddr_addr_t      hold_dec;

    logic            cmd_valid;
    cmd_code_t       cmd_code;
    logic [BgW-1:0]  cmd_bg;
    logic [BaW-1:0]  cmd_ba;
    logic [RowW-1:0] cmd_row;
    logic [ColW-1:0] cmd_col;
    logic [DataW-1:0] cmd_data;

    // Invalid rw encodings are dropped before they reach the queue.
    assign push     = bus.act_cmd && (bus.data.rw == RwRead || bus.data.rw == RwWrite);
    assign hold_dec = decode_addr(hold_q.physical_addr);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock_t),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (bus.data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Busy is registered from next-cycle occupancy so it lines up with the count.
    always_comb begin
        occ_next   = count + OccW'(push && !full) - OccW'(pop);
        dev_busy_d = (occ_next >= OccW'(DEPTH - 2));
        overflow_d = overflow_q | (push & full);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        pop       = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = CmdNop;
        cmd_bg    = '0;
        cmd_ba    = '0;
        cmd_row   = '0;
        cmd_col   = '0;
        cmd_data  = '0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    state_d = StAct;
                end
            end
            StAct: begin
                cmd_valid = 1'b1;
                cmd_code  = CmdAct;
                cmd_bg    = hold_dec.bg;
                cmd_ba    = hold_dec.ba;
                cmd_row   = hold_dec.row;
                if (bus.cmd_ready) begin
                    if (T_RCD == 1) begin
                        state_d = StCas;
                    end else begin
                        state_d = StWaitRcd;
                        cnt_d   = CntW'(T_RCD - 1);
                    end
                end
            end
            StWaitRcd: begin
                // Leaves as the counter reaches zero, so the stay is T_RCD-1 clocks.
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StCas;
            end
            StCas: begin
                cmd_valid = 1'b1;
                cmd_code  = (hold_q.rw == RwWrite) ? CmdWr : CmdRd;
                cmd_bg    = hold_dec.bg;
                cmd_ba    = hold_dec.ba;
                cmd_col   = hold_dec.col;
                cmd_data  = hold_q.data_wr;
                if (bus.cmd_ready) begin
`ifdef OPEN_PAGE_EN
                    state_d = StOpen;
`else
                    state_d = StPre;
`endif
                end
            end
            StPre: begin
                cmd_valid = 1'b1;
                cmd_code  = CmdPre;
                cmd_bg    = hold_dec.bg;
                cmd_ba    = hold_dec.ba;
                if (bus.cmd_ready) begin
                    if (T_RP == 1) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StWaitRp;
                        cnt_d   = CntW'(T_RP - 1);
                    end
                end
            end
            StWaitRp: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StIdle;
            end
`ifdef OPEN_PAGE_EN
            StOpen: begin
                // Page identity is everything above the column bits: {row, bg, ba}.
                if (!empty) begin
                    if (head.physical_addr[AddrW-1:ColW] == hold_q.physical_addr[AddrW-1:ColW])
                    begin
                        pop     = 1'b1;
                        hold_d  = head;
                        state_d = StCas;
                    end else begin
                        state_d = StPre;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hold_q     <= '0;
            dev_busy_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            dev_busy_q <= dev_busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.dev_busy  = dev_busy_q;
    assign bus.overflow  = overflow_q;
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_code  = cmd_code;
    assign bus.cmd_bg    = cmd_bg;
    assign bus.cmd_ba    = cmd_ba;
    assign bus.cmd_row   = cmd_row;
    assign bus.cmd_col   = cmd_col;
    assign bus.cmd_data  = cmd_data;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: stimulus pushes expected commands, a
// negedge monitor pops and compares on every cmd handshake.
module tb_cmd_sequencer;
    import ddr_package::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned T_RCD = 4;
    localparam int unsigned T_RP  = 4;
`ifdef OPEN_PAGE_EN
    localparam int CmdsPerTxn = 2;
    localparam int PreGap     = 2;
`else
    localparam int CmdsPerTxn = 3;
    localparam int PreGap     = 1;
`endif

    logic clock_t = 1'b0;
    logic reset_n = 1'b0;

    cmd_sequencer_if bus ();

    cmd_sequencer #(
        .DEPTH (DEPTH),
        .T_RCD (T_RCD),
        .T_RP  (T_RP)
    ) dut (
        .clock_t (clock_t),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock_t = ~clock_t;

    typedef struct {
        cmd_code_t    code;
        logic [1:0]   bg;
        logic [1:0]   ba;
        logic [14:0]  row;
        logic [9:0]   col;
        logic [63:0]  data;
    } exp_cmd_t;

    exp_cmd_t  sb_q[$];
    cmd_code_t hs_code[$];
    int        hs_cyc[$];
    int        errors = 0;
    int        checks = 0;
    int        cyc = 0;
    int        ready_mode = 1;   // 0 low, 1 high, 2 random
`ifdef OPEN_PAGE_EN
    bit          pg_open = 1'b0;
    logic [28:0] pg_addr = '0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec address layout: col=[9:0] ba=[11:10] bg=[13:12] row=[28:14]
    function automatic exp_cmd_t mk(cmd_code_t c, logic [28:0] a, logic [63:0] d);
        exp_cmd_t e;
        e.code = c;
        e.col  = a[9:0];
        e.ba   = a[11:10];
        e.bg   = a[13:12];
        e.row  = a[28:14];
        e.data = d;
        return e;
    endfunction

    task automatic model_txn(input logic [28:0] a, input logic [63:0] d, input logic [1:0] rw);
        cmd_code_t cas;
        cas = (rw == 2'b10) ? CmdWr : CmdRd;
`ifdef OPEN_PAGE_EN
        if (pg_open && pg_addr[28:10] == a[28:10]) begin
            sb_q.push_back(mk(cas, a, d));
        end else begin
            if (pg_open) sb_q.push_back(mk(CmdPre, pg_addr, '0));
            sb_q.push_back(mk(CmdAct, a, d));
            sb_q.push_back(mk(cas, a, d));
            pg_open = 1'b1;
            pg_addr = a;
        end
`else
        sb_q.push_back(mk(CmdAct, a, d));
        sb_q.push_back(mk(cas, a, d));
        sb_q.push_back(mk(CmdPre, a, d));
`endif
    endtask

    always @(posedge clock_t) cyc <= cyc + 1;

    always @(posedge clock_t) begin
        #1;
        if (ready_mode == 0)      bus.cmd_ready = 1'b0;
        else if (ready_mode == 1) bus.cmd_ready = 1'b1;
        else                      bus.cmd_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor
    logic [96:0] cur_vec, prev_vec;
    bit          prev_stall = 1'b0;
    exp_cmd_t    mon_e;
    always @(negedge clock_t) begin
        cur_vec = {bus.cmd_valid, bus.cmd_code, bus.cmd_bg, bus.cmd_ba, bus.cmd_row,
                   bus.cmd_col, bus.cmd_data};
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (!bus.cmd_valid) check("nop_when_invalid", bus.cmd_code, CmdNop);
            if (prev_stall) check("stable_while_stalled", cur_vec, prev_vec);
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs_code.push_back(bus.cmd_code);
                hs_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got code %0d, none expected", bus.cmd_code);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("cmd_code", bus.cmd_code, mon_e.code);
                    if (mon_e.code != CmdNop) begin
                        check("cmd_bg", bus.cmd_bg, mon_e.bg);
                        check("cmd_ba", bus.cmd_ba, mon_e.ba);
                    end
                    if (mon_e.code == CmdAct) check("cmd_row", bus.cmd_row, mon_e.row);
                    if (mon_e.code == CmdRd || mon_e.code == CmdWr)
                        check("cmd_col", bus.cmd_col, mon_e.col);
                    if (mon_e.code == CmdWr) check("cmd_data", bus.cmd_data, mon_e.data);
                end
            end
            prev_stall = bus.cmd_valid && !bus.cmd_ready;
        end
        prev_vec = cur_vec;
    end

    // Called at posedge+1; drives one strobe for the next edge.
    task automatic strobe(input logic [28:0] a, input logic [63:0] d, input logic [1:0] rw,
                          input bit accept);
        bus.act_cmd = 1'b1;
        bus.data    = {a, d, rw};
        if (accept && (rw == 2'b01 || rw == 2'b10)) model_txn(a, d, rw);
        @(posedge clock_t);
        #1;
        bus.act_cmd = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb_q.delete();
        hs_code.delete();
        hs_cyc.delete();
`ifdef OPEN_PAGE_EN
        pg_open = 1'b0;
`endif
        #1;
        check("rst_cmd_valid", bus.cmd_valid, 1'b0);
        check("rst_cmd_code", bus.cmd_code, CmdNop);
        check("rst_dev_busy", bus.dev_busy, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_cmd_fields", {bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col, bus.cmd_data},
              '0);
        repeat (2) @(negedge clock_t);
        reset_n = 1'b1;
        @(posedge clock_t);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(posedge clock_t);
            n++;
        end
        repeat (T_RP + 8) @(posedge clock_t);
        #1;
        check({name, "_drained"}, sb_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_code_t   exp_seq[$];
        logic [28:0] a;
        logic [1:0]  rw;
        int          occ, n;

        bus.act_cmd = 1'b0;
        bus.data    = '0;
        do_reset();

        // Single write followed by a read to another row
        ready_mode = 1;
        strobe(29'h0123_4567, 64'hDEAD_BEEF_0000_0001, 2'b10, 1'b1);
        strobe(29'h0ABC_D123, 64'h0, 2'b01, 1'b1);
        drain("single_write");
        check("sw_hs_count_min", hs_code.size() >= 4, 1'b1);
        if (hs_code.size() >= 4) begin
            check("sw_code0", hs_code[0], CmdAct);
            check("sw_code1", hs_code[1], CmdWr);
            check("sw_code2", hs_code[2], CmdPre);
            check("sw_code3", hs_code[3], CmdAct);
            check("sw_act_to_cas", hs_cyc[1] - hs_cyc[0], T_RCD);
            check("sw_cas_to_pre", hs_cyc[2] - hs_cyc[1], PreGap);
            check("sw_pre_to_act", hs_cyc[3] - hs_cyc[2], T_RP + 1);
        end

        // Invalid rw encodings
        n = hs_code.size();
        strobe(29'h0000_1111, 64'h1, 2'b00, 1'b1);
        strobe(29'h0000_2222, 64'h2, 2'b11, 1'b1);
        repeat (20) @(posedge clock_t);
        #1;
        check("bad_rw_no_cmd", hs_code.size(), n);
        check("bad_rw_not_busy", bus.dev_busy, 1'b0);

        // Fill with downstream stalled
        do_reset();
        ready_mode = 0;
        @(posedge clock_t);
        #1;
        for (int k = 1; k <= DEPTH + 2; k++) begin
            a = 29'($urandom);
            strobe(a, {$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
                   k != DEPTH + 2);
            // First entry moves to the holding register, later ones stack up.
            occ = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
            check("fill_dev_busy", bus.dev_busy, occ >= DEPTH - 2);
            check("fill_overflow", bus.overflow, k == DEPTH + 2);
            if (k >= 3) check("fill_act_held", {bus.cmd_valid, bus.cmd_code}, {1'b1, CmdAct});
        end
        ready_mode = 1;
        drain("fill");
        check("fill_overflow_sticky", bus.overflow, 1'b1);

        // Reset during WAIT_RCD
        do_reset();
        ready_mode = 1;
        strobe(29'h0000_4000, 64'hA, 2'b10, 1'b1);
        strobe(29'h0004_8000, 64'hB, 2'b01, 1'b1);
        strobe(29'h0008_C000, 64'hC, 2'b10, 1'b1);
        n = 0;
        while (hs_code.size() == 0 && n < 50) begin
            @(posedge clock_t);
            n++;
        end
        check("rcd_act_seen", hs_code.size() != 0, 1'b1);
        #1;
        do_reset();
        strobe(29'h1555_0ABC, 64'h1234_5678_9ABC_DEF0, 2'b10, 1'b1);
        drain("post_reset");
        check("post_reset_hs_count", hs_code.size(), CmdsPerTxn);
        if (hs_code.size() != 0) check("post_reset_first_act", hs_code[0], CmdAct);

        // Same-row reads then a different row
        do_reset();
        ready_mode = 1;
        strobe({15'h1234, 2'b01, 2'b10, 10'h010}, 64'h0, 2'b01, 1'b1);
        strobe({15'h1234, 2'b01, 2'b10, 10'h020}, 64'h0, 2'b01, 1'b1);
        strobe({15'h0777, 2'b01, 2'b10, 10'h030}, 64'h0, 2'b01, 1'b1);
        drain("page");
`ifdef OPEN_PAGE_EN
        exp_seq = '{CmdAct, CmdRd, CmdRd, CmdPre, CmdAct, CmdRd};
`else
        exp_seq = '{CmdAct, CmdRd, CmdPre, CmdAct, CmdRd, CmdPre, CmdAct, CmdRd, CmdPre};
`endif
        check("page_hs_count", hs_code.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < hs_code.size(); i++)
            check("page_seq", hs_code[i], exp_seq[i]);

        // Random traffic with random downstream stalls
        do_reset();
        ready_mode = 2;
        for (int t = 0; t < 110; t++) begin
            n = 0;
            while (bus.dev_busy && n < 200) begin
                @(posedge clock_t);
                #1;
                n++;
            end
            if (n >= 200) check("rand_busy_timeout", 1'b1, 1'b0);
            a  = {15'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
                  2'($urandom_range(0, 1)), 10'($urandom)};
            rw = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11)
                                             : (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
            strobe(a, {$urandom, $urandom}, rw, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clock_t);
                #1;
            end
        end
        drain("random");
        check("random_no_overflow", bus.overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
